// File: rtl/pixel_arbiter_rr_if.sv
// pixel_arbiter_rr_if: iterator, SRAM write port and HPS handshake bundle for the round-robin pixel arbiter
interface pixel_arbiter_rr_if #(
    parameter int N_ITER = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    logic                     key_start;
    logic                     hps_reset;
    logic [N_ITER-1:0]        iter_req;
    logic [N_ITER-1:0]        iter_done;
    logic [N_ITER*ADDR_W-1:0] iter_addr;
    logic [N_ITER*DATA_W-1:0] iter_color;
    logic [N_ITER-1:0]        iter_ack;
    logic                     iter_start;
    logic [ADDR_W-1:0]        sram_addr;
    logic [DATA_W-1:0]        sram_writedata;
    logic                     sram_write;
    logic                     hps_done;
    logic                     hps_send_done;
    logic [31:0]              hps_send_timer;
    logic [31:0]              pixel_count;

    // Arbiter side: consumes requests, drives SRAM writes, acks and HPS status
    modport master (
        input  key_start, hps_reset, iter_req, iter_done, iter_addr, iter_color,
        output iter_ack, iter_start, sram_addr, sram_writedata, sram_write,
               hps_done, hps_send_done, hps_send_timer, pixel_count
    );

    // Environment side: iterators, pushbutton, HPS and SRAM
    modport slave (
        output key_start, hps_reset, iter_req, iter_done, iter_addr, iter_color,
        input  iter_ack, iter_start, sram_addr, sram_writedata, sram_write,
               hps_done, hps_send_done, hps_send_timer, pixel_count
    );
endinterface

// File: rtl/pixel_arbiter_rr.sv
// pixel_arbiter_rr: round-robin arbiter from N Mandelbrot iterators onto the VGA SRAM write port
module pixel_arbiter_rr #(
    parameter int N_ITER       = 6,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 8,
    parameter int TICKS_PER_MS = 50000
) (
    input logic                clk,
    input logic                reset,
    pixel_arbiter_rr_if.master bus_io
);
    localparam int PW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [N_ITER-1:0] ONE = N_ITER'(1);
    localparam logic [31:0] TICK_MAX = 32'(TICKS_PER_MS - 1);
    localparam logic [31:0] LAST_CH = 32'(N_ITER - 1);

    typedef enum logic [2:0] {IDLE, START, ARM, ARB, ACK, DONE} state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     gnt_d;
    logic [PW-1:0]     idx;
    logic [31:0]       tick_q;
    logic [31:0]       ms_q;
    logic [31:0]       pix_q;
    logic [31:0]       timer_q;
    logic              start_q;
    logic              write_q;
    logic              done_q;
    logic              send_done_q;
    logic [N_ITER-1:0] ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              run;
    logic [ADDR_W-1:0] addr_a [N_ITER];
    logic [DATA_W-1:0] data_a [N_ITER];

    for (genvar i = 0; i < N_ITER; i++) begin : g_unpack
        assign addr_a[i] = bus_io.iter_addr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = bus_io.iter_color[i*DATA_W +: DATA_W];
    end

    assign run = (state_q == ARB) || (state_q == ACK);

    // First requester at or after the pointer; descending scan lets the smallest offset win
    always_comb begin
        gnt_d = ptr_q;
        idx = ptr_q;
        for (int k = N_ITER - 1; k >= 0; k--) begin
            idx = PW'((32'(ptr_q) + 32'(k)) % 32'(N_ITER));
            if (bus_io.iter_req[idx]) gnt_d = idx;
        end
    end

    // Frame FSM with registered outputs; an HPS restart overrides every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            tick_q      <= '0;
            ms_q        <= '0;
            pix_q       <= '0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            write_q     <= 1'b0;
            done_q      <= 1'b0;
            send_done_q <= 1'b0;
            ack_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            done_q  <= bus_io.hps_reset;
            start_q <= 1'b0;
            write_q <= 1'b0;
            ack_q   <= '0;
            if (run) begin
                tick_q <= (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
                if (tick_q == TICK_MAX && ms_q != '1) ms_q <= ms_q + 1'b1;
            end
            if (bus_io.hps_reset) begin
                state_q     <= START;
                send_done_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (!bus_io.key_start) state_q <= START;
                    START: begin
                        start_q     <= 1'b1;
                        tick_q      <= '0;
                        ms_q        <= '0;
                        pix_q       <= '0;
                        send_done_q <= 1'b0;
                        state_q     <= ARM;
                    end
                    ARM: state_q <= ARB;
                    ARB: begin
                        if (|bus_io.iter_req) begin
                            write_q <= 1'b1;
                            ack_q   <= ONE << gnt_d;
                            addr_q  <= addr_a[gnt_d];
                            data_q  <= data_a[gnt_d];
                            pix_q   <= pix_q + 1'b1;
                            ptr_q   <= (32'(gnt_d) == LAST_CH) ? '0 : gnt_d + 1'b1;
                            state_q <= ACK;
                        end else if (&bus_io.iter_done) begin
                            state_q <= DONE;
                        end
                    end
                    ACK: state_q <= ARB;
                    DONE: begin
                        timer_q     <= ms_q;
                        send_done_q <= 1'b1;
                        if (!bus_io.key_start) state_q <= START;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus_io.iter_ack       = ack_q;
    assign bus_io.iter_start     = start_q;
    assign bus_io.sram_addr      = addr_q;
    assign bus_io.sram_writedata = data_q;
    assign bus_io.sram_write     = write_q;
    assign bus_io.hps_done       = done_q;
    assign bus_io.hps_send_done  = send_done_q;
    assign bus_io.hps_send_timer = timer_q;
    assign bus_io.pixel_count    = pix_q;
endmodule
